// File: rtl/pong_score_keeper.sv
// pong_score_keeper: two-digit BCD Pong scores with a serve pause, win detection and a held game-over state.
module pong_score_keeper #(
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       point_l,
    input  logic       point_r,
    output logic [3:0] score_l_tens,
    output logic [3:0] score_l_ones,
    output logic [3:0] score_r_tens,
    output logic [3:0] score_r_ones,
    output logic       serve_en,
    output logic       game_over,
    output logic       winner
);
    typedef enum logic [1:0] {IDLE, HOLD, PLAY, OVER} state_t;
    state_t state_q, state_d;
    logic [3:0] lt_q, lt_d, lo_q, lo_d, rt_q, rt_d, ro_q, ro_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic winner_q, winner_d, serve_q, serve_d, over_q, over_d;
    logic prev_l_q, prev_r_q, edge_l, edge_r, hold_done, win;
    logic [7:0] inc_l, inc_r;

    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        return (o < 4'd9) ? {t, o + 4'd1} : {t + 4'd1, 4'd0};
    endfunction

    function automatic logic [6:0] bcd_val(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    assign edge_l    = point_l & ~prev_l_q;
    assign edge_r    = point_r & ~prev_r_q;
    assign inc_l     = bcd_inc(lt_q, lo_q);
    assign inc_r     = bcd_inc(rt_q, ro_q);
    assign hold_done = cnt_q == HOLD_W'(HOLD_CYCLES - 1);
    assign win       = bcd_val(edge_l ? inc_l : inc_r) == 7'(WIN_SCORE);

    always_comb begin
        state_d  = state_q;
        lt_d     = lt_q;
        lo_d     = lo_q;
        rt_d     = rt_q;
        ro_d     = ro_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        if (new_game) begin
            state_d  = HOLD;
            {lt_d, lo_d, rt_d, ro_d} = '0;
            cnt_d    = '0;
            winner_d = 1'b0;
        end else if (state_q == PLAY && (edge_l ^ edge_r)) begin
            {lt_d, lo_d} = edge_l ? inc_l : {lt_q, lo_q};
            {rt_d, ro_d} = edge_r ? inc_r : {rt_q, ro_q};
            state_d  = win ? OVER : HOLD;
            winner_d = win ? edge_r : winner_q;
            cnt_d    = '0;
        end else if (state_q == HOLD) begin
            state_d = hold_done ? PLAY : HOLD;
            cnt_d   = hold_done ? '0 : cnt_q + 1'b1;
        end
        serve_d = state_d == PLAY;
        over_d  = state_d == OVER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            {lt_q, lo_q, rt_q, ro_q} <= '0;
            cnt_q    <= '0;
            winner_q <= 1'b0;
            serve_q  <= 1'b0;
            over_q   <= 1'b0;
            prev_l_q <= 1'b1;
            prev_r_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            lt_q     <= lt_d;
            lo_q     <= lo_d;
            rt_q     <= rt_d;
            ro_q     <= ro_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            serve_q  <= serve_d;
            over_q   <= over_d;
            prev_l_q <= point_l;
            prev_r_q <= point_r;
        end
    end

    assign score_l_tens = lt_q;
    assign score_l_ones = lo_q;
    assign score_r_tens = rt_q;
    assign score_r_ones = ro_q;
    assign serve_en     = serve_q;
    assign game_over    = over_q;
    assign winner       = winner_q;
endmodule

// File: tb/tb_pong_score_keeper.sv
// tb_pong_score_keeper: table-driven vectors plus hand sequences, checked through an expected-output queue.
module tb_pong_score_keeper;
    logic clk = 1'b0, reset = 1'b1, new_game = 1'b0, point_l = 1'b0, point_r = 1'b0;
    logic [3:0] score_l_tens, score_l_ones, score_r_tens, score_r_ones;
    logic serve_en, game_over, winner;
    int checks = 0, errors = 0;

    typedef struct {
        logic rst, ng, pl, pr;
        logic [18:0] exp;
        string name;
    } vec_t;
    typedef struct {
        logic [18:0] exp;
        string name;
    } sb_t;
    vec_t tbl[$];
    sb_t sb[$];

    pong_score_keeper #(.WIN_SCORE(11), .HOLD_CYCLES(4), .HOLD_W(3)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .point_l(point_l), .point_r(point_r),
        .score_l_tens(score_l_tens), .score_l_ones(score_l_ones),
        .score_r_tens(score_r_tens), .score_r_ones(score_r_ones),
        .serve_en(serve_en), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] o(input int lt, lo, rt, ro, input logic se, go, w);
        return {4'(lt), 4'(lo), 4'(rt), 4'(ro), se, go, w};
    endfunction

    task automatic add(input logic r, ng, pl, pr, input logic [18:0] e, input string nm);
        vec_t v;
        v.rst = r; v.ng = ng; v.pl = pl; v.pr = pr; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic cyc(input logic r, ng, pl, pr, input logic [18:0] e, input string nm);
        sb_t s, p;
        logic [18:0] got;
        @(negedge clk);
        reset = r; new_game = ng; point_l = pl; point_r = pr;
        s.exp = e; s.name = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        got = {score_l_tens, score_l_ones, score_r_tens, score_r_ones, serve_en, game_over, winner};
        checks++;
        if (got !== p.exp) begin
            errors++;
            $display("FAIL %s: got %h (lt lo rt ro se go w) expected %h", p.name, got, p.exp);
        end
    endtask

    initial begin
        add(1, 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "reset");
        add(0, 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "idle_pl_high");
        add(0, 1, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "ng_hold");
        add(0, 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "hold1");
        add(0, 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "hold2");
        add(0, 0, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "hold3");
        add(0, 0, 1, 0, o(0, 0, 0, 0, 1, 0, 0), "play_rise");
        add(0, 0, 1, 0, o(0, 0, 0, 0, 1, 0, 0), "pl_held_no_point");
        add(0, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0), "play_idle");
        add(0, 0, 1, 1, o(0, 0, 0, 0, 1, 0, 0), "simul_edges");
        add(0, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0), "simul_after");
        add(0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0), "left_point");
        add(0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0), "hold_a");
        add(0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0), "hold_edge_ignored");
        add(0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0), "hold_c");
        add(0, 0, 1, 0, o(0, 1, 0, 0, 1, 0, 0), "hold_done");
        add(0, 0, 0, 0, o(0, 1, 0, 0, 1, 0, 0), "play_again");
        foreach (tbl[i]) cyc(tbl[i].rst, tbl[i].ng, tbl[i].pl, tbl[i].pr, tbl[i].exp, tbl[i].name);

        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0, 1, o(0, 1, i / 10, i % 10, 0, 0, 0), "r_point");
            for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, o(0, 1, i / 10, i % 10, 0, 0, 0), "r_hold");
            cyc(0, 0, 0, 0, o(0, 1, i / 10, i % 10, 1, 0, 0), "r_play");
        end

        cyc(0, 0, 0, 1, o(0, 1, 1, 1, 0, 1, 1), "win");
        cyc(0, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 1), "frozen");
        cyc(0, 0, 1, 0, o(0, 1, 1, 1, 0, 1, 1), "frozen_pl");
        cyc(0, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 1), "frozen");
        cyc(0, 0, 0, 1, o(0, 1, 1, 1, 0, 1, 1), "frozen_pr");
        cyc(0, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 1), "frozen");
        cyc(0, 0, 1, 1, o(0, 1, 1, 1, 0, 1, 1), "frozen_both");
        cyc(0, 0, 0, 0, o(0, 1, 1, 1, 0, 1, 1), "frozen");

        cyc(0, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "ng_over");
        for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "ng_hold");
        cyc(0, 0, 0, 0, o(0, 0, 0, 0, 1, 0, 0), "ng_play");
        cyc(0, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0), "l_point2");
        for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0), "l_hold2");
        cyc(0, 0, 0, 0, o(0, 1, 0, 0, 1, 0, 0), "play3");
        cyc(0, 1, 1, 0, o(0, 0, 0, 0, 0, 0, 0), "ng_vs_point");
        cyc(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "hold_mid");
        cyc(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "reset_mid_hold");
        for (int j = 0; j < 6; j++) cyc(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0), "idle_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pong_score_keeper.md
# pong_score_keeper

Match scorekeeper for Pong. Counts points for the left and right players as two-digit BCD values and enforces a serve pause after each point. Detects the winning score and holds the game over until a new game starts. Its four 4-bit digit outputs feed the four 7-segment hex decoders directly. Its `serve_en` output gates ball motion in the game logic.

## Interface
Parameters:
- `WIN_SCORE`, default 11: points that end the game; legal range 1..99.
- `HOLD_CYCLES`, default 50_000_000: serve-pause length in clocks, ≥1 (1 s at 50 MHz).
- `HOLD_W`, default 26: hold counter width; must hold `HOLD_CYCLES-1`.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `new_game`, in, 1: start/restart request, sampled each clock.
- `point_l`, in, 1: level from game logic; rising edge = left player scores.
- `point_r`, in, 1: level from game logic; rising edge = right player scores.
- `score_l_tens`, out, 4: left score, BCD tens digit.
- `score_l_ones`, out, 4: left score, BCD ones digit.
- `score_r_tens`, out, 4: right score, BCD tens digit.
- `score_r_ones`, out, 4: right score, BCD ones digit.
- `serve_en`, out, 1: ball may move (high only in PLAY).
- `game_over`, out, 1: high only in OVER.
- `winner`, out, 1: 0 = left, 1 = right; valid only while `game_over` = 1.

## Operation
- Reset values: all digits 0, state IDLE, `serve_en` 0, `game_over` 0, `winner` 0, hold counter 0.
- Reset also sets both edge-detect history registers to 1. A point line already high when reset releases is not counted.
- Edge detection: `edge_l = point_l & ~prev_l`, and likewise for the right side. Both history registers update every clock, in every state.
- States and transitions:
  - IDLE: `new_game` → HOLD. Point edges are ignored.
  - HOLD: `serve_en` 0; the counter increments each clock. When the counter equals `HOLD_CYCLES-1` → PLAY, counter cleared. Point edges are ignored.
  - PLAY: `serve_en` 1. Exactly one of `edge_l`/`edge_r` awards a point to that side. The state then goes to OVER if the new score equals `WIN_SCORE`, otherwise to HOLD.
  - OVER: `game_over` 1; `winner` and scores are frozen. Point edges are ignored. `new_game` → HOLD.
- On `new_game` from IDLE, HOLD, PLAY or OVER: clear all four digits, clear the hold counter, `winner` ← 0, go to HOLD.
- Priority order: `reset` > `new_game` > point edges > hold expiry.
- Simultaneous `edge_l` and `edge_r` in PLAY: neither side is awarded; state stays PLAY.
- BCD increment: if ones < 9, ones + 1. Otherwise ones ← 0 and tens + 1. Digits never hold values above 9.
- The win comparison uses the incremented score, i.e. tens×10 + ones computed from the next-state digits. The game can never reach 99+1.

## Timing
- Point latency: `point_l` seen high at clock edge k, after being low at edge k-1, with state PLAY. At edge k: digits update, `serve_en` falls, and the state becomes HOLD or OVER. Everything is registered, so all changes are visible in the cycle after edge k.
- After PLAY→HOLD, `serve_en` stays 0 for exactly `HOLD_CYCLES` clocks, then rises.
- `new_game` latency: one edge. Digits read 0 and state is HOLD in the next cycle.
- A point line held high produces exactly one point. It must fall and rise again to score again.
- Outputs are pure registers; there is no combinational path from inputs to outputs.

## Test plan
Bench parameters: `WIN_SCORE`=11, `HOLD_CYCLES`=4.
- Reset with `point_l` held high, release reset, then pulse `new_game` → no point counted. `serve_en` rises exactly 4 clocks after state enters HOLD. All digits 0.
- In PLAY, 10 single-cycle `point_r` pulses, each sent after `serve_en` is high → right digits step 0..9 then tens=1/ones=0. `serve_en` 0 for 4 clocks after each point.
- Right at 10, send one more `point_r` edge → digits 1/1, `game_over`=1, `winner`=1, `serve_en`=0. Further `point_l`/`point_r` edges leave all outputs unchanged.
- `point_l` and `point_r` rise on the same edge in PLAY → no score change, `serve_en` stays 1. A `point_l` edge during HOLD → ignored.
- `new_game` asserted on the same edge as a `point_l` edge in PLAY → digits all 0, `winner` 0, state HOLD. `reset` asserted in the middle of HOLD → all reset values next cycle.
